// File: rtl/h_cmd_mux.sv
// fifo: generic single-clock FIFO with occupancy count; push/pop same cycle allowed.
// Latency: pop_dat shows the head combinationally; a push is visible the cycle after.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             push_vld,
  input  logic [W-1:0]     push_dat,
  input  logic             pop_vld,
  output logic [W-1:0]     pop_dat,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + AW'(1);
      if (pop_vld)  rd_ptr <= rd_ptr + AW'(1);
      if (push_vld && !pop_vld)      count <= count + CNT_W'(1);
      else if (!push_vld && pop_vld) count <= count - CNT_W'(1);
    end
  end

  assign pop_dat = mem[rd_ptr];
endmodule

// h_cmd_mux: round-robin N-channel command arbiter onto h, routing in-order responses back.
// Latency: command path combinational; response reaches its channel 1 cycle after h.
// Backpressure: grants stall on h not ready, drain, or DEPTH outstanding; responses never stall.
module h_cmd_mux #(
  parameter int N     = 4,
  parameter int DEPTH = 4,
  parameter int K_W   = 32,
  parameter int V_W   = 32,
  parameter int OP_W  = 3,
  parameter int ST_W  = 3
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [N-1:0]      i_ch_cmd_vld,
  input  logic [N*OP_W-1:0] i_ch_cmd_opcode,
  input  logic [N*K_W-1:0]  i_ch_cmd_k,
  input  logic [N*V_W-1:0]  i_ch_cmd_v,
  output logic [N-1:0]      o_ch_cmd_rdy,
  output logic [N-1:0]      o_ch_rsp_vld,
  output logic [ST_W-1:0]   o_ch_rsp_status,
  output logic [V_W-1:0]    o_ch_rsp_v,
  output logic              o_h_cmd_vld,
  output logic [OP_W-1:0]   o_h_cmd_opcode,
  output logic [K_W-1:0]    o_h_cmd_k,
  output logic [V_W-1:0]    o_h_cmd_v,
  input  logic              i_h_cmd_rdy,
  input  logic              i_h_rsp_vld,
  input  logic [ST_W-1:0]   i_h_rsp_status,
  input  logic [V_W-1:0]    i_h_rsp_v,
  input  logic              i_drain,
  output logic              o_idle,
  output logic              o_err
);
  localparam int CH_W  = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [OP_W-1:0] opcode;
    logic [K_W-1:0]  k;
    logic [V_W-1:0]  v;
  } cmd_t;

  cmd_t             ch_cmd [N];
  cmd_t             gnt_cmd;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  gnt;
  logic             any_vld;
  logic             can_issue;
  logic             accept;
  logic             pop;
  logic [CH_W-1:0]  head_ch;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] cnt_nxt;
  int               idx;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ch_cmd[i].opcode = i_ch_cmd_opcode[i*OP_W +: OP_W];
      ch_cmd[i].k      = i_ch_cmd_k[i*K_W +: K_W];
      ch_cmd[i].v      = i_ch_cmd_v[i*V_W +: V_W];
    end
  end

  // first requester at or after rr_ptr, searching circularly
  always_comb begin
    gnt     = rr_ptr;
    any_vld = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(rr_ptr) + i) % N;
      if (!any_vld && i_ch_cmd_vld[idx]) begin
        gnt     = CH_W'(idx);
        any_vld = 1'b1;
      end
    end
  end

  // full is judged on the registered count, so a same-cycle pop never frees a slot
  assign can_issue      = ~i_drain & (count < CNT_W'(DEPTH));
  assign o_h_cmd_vld    = can_issue & any_vld;
  assign accept         = o_h_cmd_vld & i_h_cmd_rdy;
  assign gnt_cmd        = ch_cmd[gnt];
  assign o_h_cmd_opcode = gnt_cmd.opcode;
  assign o_h_cmd_k      = gnt_cmd.k;
  assign o_h_cmd_v      = gnt_cmd.v;

  always_comb begin
    o_ch_cmd_rdy = '0;
    if (accept) o_ch_cmd_rdy[gnt] = 1'b1;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (int'(gnt) == N - 1) ? '0 : gnt + CH_W'(1);
    end
  end

  assign pop = i_h_rsp_vld & (count != '0);

  fifo #(
    .W     (CH_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk      (clk),
    .arst     (arst),
    .push_vld (accept),
    .push_dat (gnt),
    .pop_vld  (pop),
    .pop_dat  (head_ch),
    .count    (count)
  );

  always_comb begin
    cnt_nxt = count;
    if (accept && !pop)      cnt_nxt = count + CNT_W'(1);
    else if (!accept && pop) cnt_nxt = count - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      o_ch_rsp_vld    <= '0;
      o_ch_rsp_status <= '0;
      o_ch_rsp_v      <= '0;
      o_idle          <= 1'b1;
      o_err           <= 1'b0;
    end else begin
      o_ch_rsp_vld <= pop ? (N'(1) << head_ch) : '0;
      if (pop) begin
        o_ch_rsp_status <= i_h_rsp_status;
        o_ch_rsp_v      <= i_h_rsp_v;
      end
      o_idle <= (cnt_nxt == '0);
      // a response with nothing outstanding means h and the mux lost sync
      if (i_h_rsp_vld && count == '0) o_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_h_cmd_mux.sv
// Bench for h_cmd_mux: directed scenarios then random traffic, checked against a
// queue-based model of the round-robin grant and in-order response routing.
module tb_h_cmd_mux;
  localparam int N = 4, DEPTH = 4, K_W = 32, V_W = 32, OP_W = 3, ST_W = 3;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  logic [N-1:0]      ch_vld;
  logic [OP_W-1:0]   ch_op [N];
  logic [K_W-1:0]    ch_k  [N];
  logic [V_W-1:0]    ch_v  [N];
  logic [N*OP_W-1:0] op_bus;
  logic [N*K_W-1:0]  k_bus;
  logic [N*V_W-1:0]  v_bus;
  logic              h_rdy, h_rsp_vld, drain;
  logic [ST_W-1:0]   h_st;
  logic [V_W-1:0]    h_v;

  logic [N-1:0]    o_ch_cmd_rdy, o_ch_rsp_vld;
  logic [ST_W-1:0] o_ch_rsp_status;
  logic [V_W-1:0]  o_ch_rsp_v;
  logic            o_h_cmd_vld;
  logic [OP_W-1:0] o_h_cmd_opcode;
  logic [K_W-1:0]  o_h_cmd_k;
  logic [V_W-1:0]  o_h_cmd_v;
  logic            o_idle, o_err;

  always_comb begin
    op_bus = '0;
    k_bus  = '0;
    v_bus  = '0;
    for (int i = 0; i < N; i++) begin
      op_bus[i*OP_W +: OP_W] = ch_op[i];
      k_bus[i*K_W +: K_W]    = ch_k[i];
      v_bus[i*V_W +: V_W]    = ch_v[i];
    end
  end

  h_cmd_mux #(.N(N), .DEPTH(DEPTH), .K_W(K_W), .V_W(V_W), .OP_W(OP_W), .ST_W(ST_W)) dut (
    .clk(clk), .arst(arst),
    .i_ch_cmd_vld(ch_vld), .i_ch_cmd_opcode(op_bus), .i_ch_cmd_k(k_bus), .i_ch_cmd_v(v_bus),
    .o_ch_cmd_rdy(o_ch_cmd_rdy), .o_ch_rsp_vld(o_ch_rsp_vld),
    .o_ch_rsp_status(o_ch_rsp_status), .o_ch_rsp_v(o_ch_rsp_v),
    .o_h_cmd_vld(o_h_cmd_vld), .o_h_cmd_opcode(o_h_cmd_opcode),
    .o_h_cmd_k(o_h_cmd_k), .o_h_cmd_v(o_h_cmd_v), .i_h_cmd_rdy(h_rdy),
    .i_h_rsp_vld(h_rsp_vld), .i_h_rsp_status(h_st), .i_h_rsp_v(h_v),
    .i_drain(drain), .o_idle(o_idle), .o_err(o_err)
  );

  int tests = 0;
  int fails = 0;

  // reference model state
  int              tagq[$];
  int              rr;
  bit              err_m;
  logic [N-1:0]    m_rsp_vld;
  logic [ST_W-1:0] m_st;
  logic [V_W-1:0]  m_v;
  int              last_gnt;
  int              gcnt [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    tagq.delete();
    rr = 0;
    err_m = 1'b0;
    m_rsp_vld = '0;
    m_st = '0;
    m_v = '0;
  endtask

  // One clock: check combinational outputs, clock, advance the model, check registered outputs.
  task automatic cycle();
    int g;
    bit can, hv, pop;
    logic [N-1:0] erdy;
    #1;
    g = -1;
    for (int i = 0; i < N; i++) if (g < 0 && ch_vld[(rr + i) % N]) g = (rr + i) % N;
    can = !drain && (tagq.size() < DEPTH);
    hv = can && (g >= 0);
    erdy = '0;
    if (hv && h_rdy) erdy[g] = 1'b1;
    check("h_cmd_vld", 64'(o_h_cmd_vld), 64'(hv));
    check("ch_cmd_rdy", 64'(o_ch_cmd_rdy), 64'(erdy));
    if (hv) begin
      check("h_cmd_opcode", 64'(o_h_cmd_opcode), 64'(ch_op[g]));
      check("h_cmd_k", 64'(o_h_cmd_k), 64'(ch_k[g]));
      check("h_cmd_v", 64'(o_h_cmd_v), 64'(ch_v[g]));
    end
    pop = h_rsp_vld && (tagq.size() > 0);
    if (h_rsp_vld && !pop) err_m = 1'b1;
    last_gnt = (hv && h_rdy) ? g : -1;
    @(posedge clk);
    m_rsp_vld = '0;
    if (pop) begin
      m_rsp_vld[tagq.pop_front()] = 1'b1;
      m_st = h_st;
      m_v = h_v;
    end
    if (last_gnt >= 0) begin
      tagq.push_back(last_gnt);
      rr = (last_gnt + 1) % N;
    end
    #1;
    check("ch_rsp_vld", 64'(o_ch_rsp_vld), 64'(m_rsp_vld));
    check("ch_rsp_status", 64'(o_ch_rsp_status), 64'(m_st));
    check("ch_rsp_v", 64'(o_ch_rsp_v), 64'(m_v));
    check("idle", 64'(o_idle), 64'(tagq.size() == 0));
    check("err", 64'(o_err), 64'(err_m));
  endtask

  task automatic drain_rsp();
    ch_vld = '0;
    h_rsp_vld = 1'b1;
    for (int i = 0; i < DEPTH + 1 && tagq.size() > 0; i++) begin
      h_v = V_W'($urandom);
      h_st = ST_W'($urandom);
      cycle();
    end
    h_rsp_vld = 1'b0;
  endtask

  initial begin
    arst = 1'b1;
    ch_vld = '0; h_rdy = 1'b0; h_rsp_vld = 1'b0; drain = 1'b0; h_st = '0; h_v = '0;
    for (int i = 0; i < N; i++) begin
      ch_op[i] = OP_W'(i + 1);
      ch_k[i]  = K_W'(32'h100 * (i + 1));
      ch_v[i]  = V_W'(32'h1000 + i);
      gcnt[i]  = 0;
    end
    model_reset();
    #2;
    check("rst_rsp_vld", 64'(o_ch_rsp_vld), 64'(0));
    check("rst_status", 64'(o_ch_rsp_status), 64'(0));
    check("rst_v", 64'(o_ch_rsp_v), 64'(0));
    check("rst_idle", 64'(o_idle), 64'(1));
    check("rst_err", 64'(o_err), 64'(0));
    @(posedge clk);
    #1;
    arst = 1'b0;

    // round-robin fairness with all channels requesting
    ch_vld = 4'hF;
    h_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      h_rsp_vld = (tagq.size() > 0);
      h_v = V_W'($urandom);
      cycle();
      check("rr_order", 64'(last_gnt), 64'(i % 4));
      if (last_gnt >= 0) gcnt[last_gnt]++;
    end
    for (int i = 0; i < N; i++) check("rr_share", 64'(gcnt[i]), 64'(2));
    drain_rsp();

    // full FIFO blocks grants; a pop frees a slot only the following cycle
    ch_vld = 4'hF;
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      check("fill_accept", 64'(last_gnt >= 0), 64'(1));
    end
    #1;
    check("full_rdy", 64'(o_ch_cmd_rdy), 64'(0));
    h_rsp_vld = 1'b1;
    cycle();
    check("full_pop_no_gnt", 64'(last_gnt), 64'(-1));
    h_rsp_vld = 1'b0;
    cycle();
    check("after_pop_gnt", 64'(last_gnt >= 0), 64'(1));
    drain_rsp();

    // responses routed back to the issuing channel in order
    ch_vld = 4'b0100;
    ch_k[2] = 32'h10;
    cycle();
    check("t3_gnt_ch2", 64'(last_gnt), 64'(2));
    ch_vld = 4'b0001;
    ch_k[0] = 32'h20;
    #1;
    check("t3_k20", 64'(o_h_cmd_k), 64'(32'h20));
    cycle();
    check("t3_gnt_ch0", 64'(last_gnt), 64'(0));
    ch_vld = '0;
    h_rsp_vld = 1'b1;
    h_v = 32'hA;
    cycle();
    check("t3_rsp1_vld", 64'(o_ch_rsp_vld), 64'(4'b0100));
    check("t3_rsp1_v", 64'(o_ch_rsp_v), 64'(32'hA));
    h_v = 32'hB;
    cycle();
    check("t3_rsp2_vld", 64'(o_ch_rsp_vld), 64'(4'b0001));
    check("t3_rsp2_v", 64'(o_ch_rsp_v), 64'(32'hB));
    h_rsp_vld = 1'b0;
    cycle();
    check("t3_rsp_clear", 64'(o_ch_rsp_vld), 64'(0));

    // drain: 3 outstanding (grants 1,2,0 from rr=1), block, empty, resume at rr=1
    ch_vld = 4'b0111;
    for (int i = 0; i < 3; i++) cycle();
    ch_vld = 4'hF;
    drain = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("drain_no_gnt", 64'(last_gnt), 64'(-1));
    end
    h_rsp_vld = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    h_rsp_vld = 1'b0;
    check("drain_idle", 64'(o_idle), 64'(1));
    drain = 1'b0;
    cycle();
    check("drain_resume", 64'(last_gnt), 64'(1));
    drain_rsp();

    // response with nothing outstanding
    h_rsp_vld = 1'b1;
    cycle();
    h_rsp_vld = 1'b0;
    check("orphan_no_vld", 64'(o_ch_rsp_vld), 64'(0));
    check("orphan_err", 64'(o_err), 64'(1));
    for (int i = 0; i < 3; i++) cycle();
    check("err_sticky", 64'(o_err), 64'(1));

    // asynchronous reset mid-traffic with 2 outstanding and a live response
    ch_vld = 4'hF;
    cycle();
    cycle();
    h_rsp_vld = 1'b1;
    h_v = 32'h5A5A;
    h_st = 3'd5;
    cycle();
    h_rsp_vld = 1'b0;
    ch_vld = '0;
    check("pre_rst_outstanding", 64'(tagq.size()), 64'(2));
    arst = 1'b1;
    #1;
    check("arst_rsp_vld", 64'(o_ch_rsp_vld), 64'(0));
    check("arst_status", 64'(o_ch_rsp_status), 64'(0));
    check("arst_v", 64'(o_ch_rsp_v), 64'(0));
    check("arst_idle", 64'(o_idle), 64'(1));
    check("arst_err", 64'(o_err), 64'(0));
    @(posedge clk);
    #1;
    arst = 1'b0;
    model_reset();
    ch_vld = 4'hF;
    cycle();
    check("post_rst_gnt", 64'(last_gnt), 64'(0));
    drain_rsp();

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!ch_vld[i] || last_gnt == i) begin
          ch_vld[i] = ($urandom_range(0, 9) < 6);
          ch_op[i]  = OP_W'($urandom);
          ch_k[i]   = K_W'($urandom);
          ch_v[i]   = V_W'($urandom);
        end
      end
      h_rdy = ($urandom_range(0, 3) != 0);
      drain = ($urandom_range(0, 9) == 0);
      h_rsp_vld = (tagq.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 99) == 0);
      h_st = ST_W'($urandom);
      h_v = V_W'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
